// File: rtl/counter_load_ctrl_pkg.sv
// rtl/counter_load_ctrl_pkg.sv - shared FSM encodings and helpers for counter_load_ctrl
package counter_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_WAIT = 3'd1,
        ST_LOAD       = 3'd2,
        ST_HELD       = 3'd3,
        ST_REL_WAIT   = 3'd4
    } state_e;

    // Width needed to hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with asynchronous active-low reset
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/counter_load_ctrl.sv
// rtl/counter_load_ctrl.sv - debounced pushbutton to one-cycle Load strobe plus latched switch Data
module counter_load_ctrl
    import counter_load_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Btn_raw,
    input  logic [3:0] Sw_raw,
    output logic       Load,
    output logic [3:0] Data,
    output logic       Busy
);

    localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int RPT_W = cnt_width(REPEAT_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST = (REPEAT_CYCLES == 0) ? '0 : RPT_W'(REPEAT_CYCLES - 1);

    logic       btn_s;
    logic [3:0] sw_s;

    state_e           state_q, state_d;
    logic [DB_W-1:0]  db_q, db_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             load_q;
    logic [3:0]       data_q;
    logic             busy_q;

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk_i   (CLK),
        .rst_n_i (RST_n),
        .d_i     (Btn_raw),
        .q_o     (btn_s)
    );

    sync_2ff #(.WIDTH(4)) u_sync_sw (
        .clk_i   (CLK),
        .rst_n_i (RST_n),
        .d_i     (Sw_raw),
        .q_o     (sw_s)
    );

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        rpt_d   = rpt_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_WAIT;
                    db_d    = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (db_q == DB_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_HELD;
                rpt_d   = '0;
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_REL_WAIT;
                    db_d    = '0;
                end else if (REPEAT_CYCLES != 0 && rpt_q == RPT_LAST) begin
                    state_d = ST_LOAD;
                end else if (rpt_q != '1) begin
                    // Saturates so a long hold with repeat disabled never wraps.
                    rpt_d = rpt_q + RPT_W'(1);
                end
            end
            ST_REL_WAIT: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    rpt_d   = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so they stay aligned with state_q.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;
            db_q    <= '0;
            rpt_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= 4'h0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            db_q    <= db_d;
            rpt_q   <= rpt_d;
            load_q  <= (state_d == ST_LOAD);
            busy_q  <= (state_d != ST_IDLE);
            if (state_d == ST_LOAD) begin
                data_q <= sw_s;
            end
        end
    end

    assign Load = load_q;
    assign Data = data_q;
    assign Busy = busy_q;

endmodule
